// File: rtl/btb_pkg.sv
// Shared definitions for the fetch-stage branch target buffer.
//
// Contents:
//   CTR_*      2-bit saturating direction counter encodings
//   TAG_W      tag width (pc[31:2])
//   BTB_AGE_W  LRU age field width used by btb_entry_t (matches the
//              default table depth of 8 entries)
//   btb_entry_t one table entry {valid, tag, target, ctr, age}
package btb_pkg;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    localparam int TAG_W     = 30;
    localparam int BTB_AGE_W = 3;

    typedef struct packed {
        logic                 valid;
        logic [TAG_W-1:0]     tag;
        logic [31:0]          target;
        logic [1:0]           ctr;
        logic [BTB_AGE_W-1:0] age;
    } btb_entry_t;

endpackage

// File: rtl/btb_lru.sv
// LRU age tracker for the branch target buffer.
//
// Holds one age per entry; ages are always a permutation of 0..ENTRIES-1,
// with 0 the most recently used and ENTRIES-1 the replacement victim.
//
// Ports:
//   clk          clock
//   rst          synchronous active-low reset (age[i] <- i)
//   touch_en_i   mark touch_idx_i as most recently used this edge
//   touch_idx_i  entry being touched
//   victim_idx_o entry whose age is ENTRIES-1
module btb_lru #(
    parameter int ENTRIES = 8,
    parameter int IDX_W   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             touch_en_i,
    input  logic [IDX_W-1:0] touch_idx_i,
    output logic [IDX_W-1:0] victim_idx_o
);

    logic [IDX_W-1:0] age_q [ENTRIES];
    logic [IDX_W-1:0] age_d [ENTRIES];

    always_comb begin
        age_d        = age_q;
        victim_idx_o = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (age_q[i] == IDX_W'(ENTRIES - 1)) begin
                victim_idx_o = IDX_W'(i);
            end
        end
        if (touch_en_i) begin
            // Entries younger than the touched one age by one; the touched
            // entry becomes youngest. This keeps the ages a permutation.
            for (int i = 0; i < ENTRIES; i++) begin
                if (age_q[i] < age_q[touch_idx_i]) begin
                    age_d[i] = age_q[i] + IDX_W'(1);
                end
            end
            age_d[touch_idx_i] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                age_q[i] <= IDX_W'(i);
            end
        end else begin
            age_q <= age_d;
        end
    end

endmodule

// File: rtl/btb_predictor.sv
// Fetch-stage branch target buffer with 2-bit saturating direction counters.
//
// Lookup of if_pc is combinational against the pre-edge table (no bypass).
// The EX-resolved branch trains the table at the clock edge and a
// mispredict (wrong direction, or taken with a stale target) raises flush.
//
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   halt            freezes the table and forces flush=0
//   if_pc           fetch PC
//   pred_taken      select pred_target as next PC
//   pred_target     predicted target (0 on miss)
//   ex_valid, ex_is_jmp, ex_pc, ex_taken, ex_target, ex_pred_taken
//                   resolved branch from EX
//   flush           mispredict, clear IF/ID and ID/EX
//   redirect_pc     correct next PC
//   lookup_hits, mispredicts (only with BTB_STATS_EN) wrapping counters
//
// Optional feature macro: BTB_STATS_EN
module btb_predictor
    import btb_pkg::*;
#(
    parameter int ENTRIES = 8,
    parameter int IDX_W   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_valid,
    input  logic        ex_is_jmp,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    output logic        flush,
    output logic [31:0] redirect_pc
`ifdef BTB_STATS_EN
    ,
    output logic [15:0] lookup_hits,
    output logic [15:0] mispredicts
`endif
);

    logic             valid_q  [ENTRIES];
    logic             valid_d  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [TAG_W-1:0] tag_d    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [31:0]      target_d [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];
    logic [1:0]       ctr_d    [ENTRIES];

    logic             f_hit, e_hit, free_hit;
    logic [IDX_W-1:0] f_idx, e_idx, free_idx, victim_idx, alloc_idx;
    logic [31:0]      e_target;
    logic             ev, mis;
    logic             touch_en;
    logic [IDX_W-1:0] touch_idx;

    // Low PC bits never take part in tagging.
    logic unused_pc_bits;
    assign unused_pc_bits = ^if_pc[1:0];

    // Fetch-side and EX-side associative searches, plus lowest free entry.
    always_comb begin
        f_hit    = 1'b0;
        f_idx    = '0;
        e_hit    = 1'b0;
        e_idx    = '0;
        free_hit = 1'b0;
        free_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && tag_q[i] == if_pc[31:2]) begin
                f_hit = 1'b1;
                f_idx = IDX_W'(i);
            end
            if (valid_q[i] && tag_q[i] == ex_pc[31:2]) begin
                e_hit = 1'b1;
                e_idx = IDX_W'(i);
            end
        end
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_hit = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    assign pred_taken  = f_hit & ctr_q[f_idx][1];
    assign pred_target = f_hit ? target_q[f_idx] : 32'h0;

    assign ev       = ex_valid & ex_is_jmp & ~halt;
    assign e_target = e_hit ? target_q[e_idx] : 32'h0;
    // Taken-and-predicted-taken still mispredicts if the stored target is stale.
    assign mis = ev & ((ex_pred_taken != ex_taken) |
                       (ex_pred_taken & ex_taken & (e_target != ex_target)));
    assign flush       = mis;
    assign redirect_pc = (ev && ex_taken) ? ex_target : ex_pc + 32'd4;

    assign alloc_idx = free_hit ? free_idx : victim_idx;

    always_comb begin
        valid_d   = valid_q;
        tag_d     = tag_q;
        target_d  = target_q;
        ctr_d     = ctr_q;
        touch_en  = 1'b0;
        touch_idx = '0;
        if (ev) begin
            if (e_hit) begin
                if (ex_taken) begin
                    target_d[e_idx] = ex_target;
                    if (ctr_q[e_idx] != CTR_ST) ctr_d[e_idx] = ctr_q[e_idx] + 2'd1;
                end else begin
                    if (ctr_q[e_idx] != CTR_SNT) ctr_d[e_idx] = ctr_q[e_idx] - 2'd1;
                end
                touch_en  = 1'b1;
                touch_idx = e_idx;
            end else if (ex_taken) begin
                valid_d[alloc_idx]  = 1'b1;
                tag_d[alloc_idx]    = ex_pc[31:2];
                target_d[alloc_idx] = ex_target;
                ctr_d[alloc_idx]    = CTR_WT;
                touch_en  = 1'b1;
                touch_idx = alloc_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= 32'h0;
                ctr_q[i]    <= CTR_WNT;
            end
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            ctr_q    <= ctr_d;
        end
    end

    btb_lru #(
        .ENTRIES(ENTRIES),
        .IDX_W  (IDX_W)
    ) u_lru (
        .clk         (clk),
        .rst         (rst),
        .touch_en_i  (touch_en),
        .touch_idx_i (touch_idx),
        .victim_idx_o(victim_idx)
    );

`ifdef BTB_STATS_EN
    logic [15:0] hits_q, hits_d;
    logic [15:0] mis_q, mis_d;

    assign hits_d = (f_hit && !halt) ? hits_q + 16'd1 : hits_q;
    assign mis_d  = flush ? mis_q + 16'd1 : mis_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            hits_q <= 16'h0;
            mis_q  <= 16'h0;
        end else begin
            hits_q <= hits_d;
            mis_q  <= mis_d;
        end
    end

    assign lookup_hits = hits_q;
    assign mispredicts = mis_q;
`endif

endmodule

// File: doc/btb_predictor.md
Name: btb_predictor

Overview:
- Fetch-stage branch target buffer with 2-bit saturating direction counters.
- Sits upstream of the IF PC mux. Given the current fetch PC, it supplies the predicted-taken select and the predicted next PC in the same cycle.
- It consumes the resolved jump/branch outcome from EX, trains its table, and raises the flush/redirect signal on a mispredict.

Parameters:
- ENTRIES, 8, number of fully-associative entries (power of 2, ≥2).
- IDX_W, 3, log2(ENTRIES); width of LRU age fields.

Ports:
- clk  in  1  system clock (divided clock clk_sys at instantiation)
- rst  in  1  synchronous, active-low reset
- halt  in  1  1 = pipeline halted by syscall; suppresses updates and flush
- if_pc  in  32  current fetch PC
- pred_taken  out  1  1 = select pred_target for next PC
- pred_target  out  32  predicted target for if_pc
- ex_valid  in  1  EX holds a non-bubble instruction
- ex_is_jmp  in  1  EX instruction is a branch/jump
- ex_pc  in  32  PC of EX instruction
- ex_taken  in  1  resolved direction
- ex_target  in  32  resolved target
- ex_pred_taken  in  1  prediction carried down the pipe for this instruction
- flush  out  1  mispredict; clear IF/ID and ID/EX
- redirect_pc  out  32  correct next PC when flush=1

Behaviour:
- Entry fields: valid, tag = pc[31:2] (30 b), target (32 b), ctr (2 b), age (IDX_W b).
- Lookup, combinational, 0 latency:
  - hit = any valid entry whose tag equals if_pc[31:2]. At most one entry can match.
  - pred_taken = hit & ctr[1].
  - pred_target = hit entry's target; 0 when there is no hit.
- Lookup reads pre-edge table contents. There is no write-to-read bypass.
- Resolution (ev = ex_valid & ex_is_jmp & ~halt):
  - mis = ev & (ex_pred_taken != ex_taken).
  - A predicted-taken, actually-taken branch with a stale target is also counted as mis. This is detected when the EX-side lookup of ex_pc returns a target ≠ ex_target.
  - flush = mis, combinational.
  - redirect_pc = ex_taken ? ex_target : ex_pc + 4.
  - flush = 0 and redirect_pc = ex_pc + 4 whenever ~ev.
- Update at posedge, when ev:
  - Hit on ex_pc: ctr saturates (+1 if taken, max 3; −1 if not, min 0). If taken, target ← ex_target. Touch the LRU.
  - Miss and taken: allocate the lowest-index invalid entry. If none is invalid, take the entry with age = ENTRIES−1. Set valid=1, tag, target=ex_target, ctr=2'b10. Touch the LRU.
  - Miss and not taken: no change.
- LRU touch of entry k: every entry with age < age[k] increments; age[k] ← 0. Ages always remain a permutation of 0..ENTRIES−1.
- Reset (rst=0 at posedge):
  - All valid ← 0, ctr ← 2'b01, target ← 0, age[i] ← i.
  - The combinational outputs are then pred_taken=0, pred_target=0, flush=0.
  - Reset has priority over a simultaneous update.
- halt=1: table frozen, flush=0. Lookup outputs remain live.
- Same PC looked up and updated in one cycle: the lookup returns the old entry, and the new value is visible next cycle.

Optional Feature:
- Macro BTB_STATS_EN.
- When defined:
  - Adds outputs lookup_hits[15:0] and mispredicts[15:0].
  - lookup_hits increments per cycle with a hit while ~halt. mispredicts increments per flush.
  - Both wrap at 16'hFFFF→0 and reset to 0.
  - Intended for Data_Choose display.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package (btb_pkg):
  - CTR_SNT=2'b00, CTR_WNT=2'b01, CTR_WT=2'b10, CTR_ST=2'b11.
  - TAG_W=30.
  - btb_entry_t struct {valid, tag, target, ctr, age}.
- Sub-module btb_lru: holds the age vector. Takes touch_en and touch_idx; outputs victim_idx. Instantiated once.

Test Plan:
- Reset, then if_pc=32'h0000_0040 → pred_taken=0, pred_target=0, flush=0.
- EX resolves pc=0x40, taken, target=0x80, ex_pred_taken=0 → flush=1, redirect_pc=0x80. Next cycle if_pc=0x40 → pred_taken=1, pred_target=0x80 (ctr=10).
- Same branch resolved not-taken twice with ex_pred_taken matching the prediction:
  - First resolution: ex_pred_taken=1 → flush=1, redirect_pc=0x44, ctr 10→01.
  - Second resolution: ex_pred_taken=0 → flush=0, ctr 01→00.
  - Then three taken resolutions → ctr saturates at 11, never wraps.
- Fill 8 distinct taken branches (0x100..0x11C), touch 0x100 again, then allocate 0x200 → the entry for 0x104 (the LRU) is evicted and 0x100 still hits.
- halt=1 with ev conditions that would mispredict → flush=0 and the table is unchanged on the following lookup.
- rst=0 asserted during an allocating update → the entry is not written; after release all lookups miss.
